rr_mux_arb: RTL and testbench

- Parametrised N-channel, W-bit arbitrating multiplexer; successor to the fixed 3:1 single-bit select muxes.
- Each input channel has a valid/ready handshake. The block picks one requesting channel per transfer by fixed priority or round-robin.
- The selected data is registered into a single output stage with valid/ready handshake.
- Sits between multiple producers and one shared consumer (bus, FIFO, or serialiser).

---
 rtl/rr_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 56 +++++
 rtl/rr_mux_arb.sv | 78 +++++++
 tb/tb_rr_mux_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants and index-width helper for the arbitrating mux.
// Contents:
//   MODE_FIXED / MODE_RR  arbitration mode selectors
//   idx_w(n)              bits needed to encode an index in [0, n-1]
package rr_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational N-way arbiter, fixed priority or round-robin.
// Ports:
//   req_i      per-channel request
//   ptr_i      round-robin start index (ignored when MODE = MODE_FIXED)
//   gnt_o      one-hot grant, zero when no request
//   gnt_idx_o  encoded index of the granted channel, zero when no request
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int MODE = MODE_FIXED,
    localparam int SW   = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [SW-1:0] gnt_idx_o
);

    logic          found;
    logic [SW-1:0] idx;

    // ptr_i is always < N, so one conditional subtraction keeps the result < N.
    function automatic logic [SW-1:0] wrap(input logic [SW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return SW'((s >= N) ? s - N : s);
    endfunction

    // Both searches let the last hit win: round-robin walks from the far end
    // of the rotated order back towards ptr, fixed walks upward so the
    // highest index survives.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (MODE == MODE_RR) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_i[wrap(ptr_i, k)]) begin
                    found = 1'b1;
                    idx   = wrap(ptr_i, k);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req_i[k]) begin
                    found = 1'b1;
                    idx   = SW'(k);
                end
            end
        end
    end

    assign gnt_o     = found ? (N'(1) << idx) : '0;
    assign gnt_idx_o = idx;

endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel W-bit arbitrating mux with a registered valid/ready output stage.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid_i    per-channel request
//   in_data_i     packed channel data, channel i at [i*W +: W]
//   in_ready_o    per-channel accept, one-hot or zero
//   out_valid_o   output register holds a word
//   out_data_o    registered data of the granted channel
//   out_sel_o     index of the channel that produced out_data_o
//   out_ready_i   consumer takes out_data_o this cycle
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int W    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int SW   = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid_i,
    input  logic [N*W-1:0] in_data_i,
    output logic [N-1:0]   in_ready_o,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic [SW-1:0]  out_sel_o,
    input  logic           out_ready_i
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt;
    logic [SW-1:0] gnt_idx;
    logic          load_en;
    logic          xfer;

    rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .req_i     (in_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // The register can take a word when empty or when it drains this cycle,
    // which gives one word per cycle with no bubble under out_ready_i.
    assign load_en    = !valid_q || out_ready_i;
    assign in_ready_o = load_en ? gnt : '0;
    // gnt only ever marks a requesting channel, so any ready bit is a transfer.
    assign xfer       = |in_ready_o;

    always_comb begin
        valid_d = xfer || (valid_q && !out_ready_i);
        data_d  = xfer ? in_data_i[gnt_idx*W +: W] : data_q;
        sel_d   = xfer ? gnt_idx : sel_q;
        ptr_d   = (MODE == MODE_RR && xfer) ? ((gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1)) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_sel_o   = sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: fixed-priority and round-robin instances checked against a behavioural model.
module tb_rr_mux_arb;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   v    [2];
    logic [N*W-1:0] d    [2];
    logic           ordy [2];
    logic [N-1:0]   ir   [2];
    logic           ov   [2];
    logic [W-1:0]   od   [2];
    logic [1:0]     os   [2];

    bit             mv  [2];
    logic [W-1:0]   md  [2];
    int             ms  [2];
    int             mp  [2];
    logic [N-1:0]   acc [2];
    int             errors = 0;
    int             checks = 0;
    int             skip_exp [3] = '{1, 2, 1};

    always #5 clk = ~clk;

    rr_mux_arb #(.N(N), .W(W), .MODE(0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(v[0]), .in_data_i(d[0]), .in_ready_o(ir[0]),
        .out_valid_o(ov[0]), .out_data_o(od[0]), .out_sel_o(os[0]), .out_ready_i(ordy[0])
    );

    rr_mux_arb #(.N(N), .W(W), .MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(v[1]), .in_data_i(d[1]), .in_ready_o(ir[1]),
        .out_valid_o(ov[1]), .out_data_o(od[1]), .out_sel_o(os[1]), .out_ready_i(ordy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 2; m++) begin
            mv[m]  = 1'b0;
            md[m]  = '0;
            ms[m]  = 0;
            mp[m]  = 0;
            acc[m] = '0;
        end
    endtask

    // Channel the rules choose: highest requester (fixed), or first requester
    // in the order ptr, ptr+1, ... modulo N (round-robin).
    function automatic int pick(input int m);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m == 0) ? N - 1 - k : (mp[m] + k) % N;
            if (v[m][i]) return i;
        end
        return -1;
    endfunction

    // Entered one time unit after a rising edge with inputs applied; returns
    // one time unit after the next rising edge.
    task automatic cycle();
        int g;
        bit le;
        logic [N-1:0] exp_ir;
        #3;
        for (int m = 0; m < 2; m++) begin
            le     = !mv[m] || ordy[m];
            g      = pick(m);
            exp_ir = (g >= 0 && le) ? N'(1 << g) : '0;
            chk($sformatf("in_ready[%0d]", m), ir[m], exp_ir);
            chk($sformatf("ready_onehot[%0d]", m), $countones(ir[m]) <= 1, 1);
            if (g >= 0 && le) begin
                mv[m] = 1'b1;
                md[m] = d[m][g*W +: W];
                ms[m] = g;
                if (m == 1) mp[m] = (g + 1) % N;
            end else if (ordy[m]) begin
                mv[m] = 1'b0;
            end
            acc[m] = exp_ir;
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("out_valid[%0d]", m), ov[m], mv[m]);
            chk($sformatf("out_data[%0d]", m), od[m], md[m]);
            chk($sformatf("out_sel[%0d]", m), os[m], ms[m]);
        end
    endtask

    // Producers hold an unaccepted request and its data; others may change.
    task automatic rand_inputs();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v[m][i] && !acc[m][i])) begin
                    v[m][i] = 1'($urandom_range(0, 1));
                    if (v[m][i]) d[m][i*W +: W] = W'($urandom);
                end
            end
            ordy[m] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        reset_model();
        for (int m = 0; m < 2; m++) begin
            v[m]    = '0;
            d[m]    = '0;
            ordy[m] = 1'b0;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                v[m]    = N'($urandom);
                d[m]    = (N*W)'($urandom);
                ordy[m] = 1'($urandom);
            end
        end
        chk("in_reset_valid", ov[1], 0);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) v[m] = '0;
        rst_n = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", ov[m], 0);
            chk("rst_data", od[m], 8'h00);
            chk("rst_sel", os[m], 0);
            chk("rst_ready", ir[m], 3'b000);
        end
        cycle();

        // All valid: fixed always picks ch2, round-robin rotates 0,1,2,...
        for (int m = 0; m < 2; m++) begin
            v[m]    = 3'b111;
            d[m]    = 24'h332211;
            ordy[m] = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("fp_sel", os[0], 2);
            chk("fp_data", od[0], 8'h33);
            chk("fp_ready", ir[0], 3'b100);
            chk("rr_sel", os[1], k % 3);
            chk("rr_valid", ov[1], 1);
        end

        // Round-robin skip over an idle ch0, pointer wrapping after ch2.
        for (int m = 0; m < 2; m++) v[m] = 3'b110;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rrskip_sel", os[1], skip_exp[k]);
            chk("rrskip_data", od[1], (skip_exp[k] == 1) ? 8'h22 : 8'h33);
        end

        // Backpressure holding 8'h22 on the round-robin instance.
        for (int m = 0; m < 2; m++) begin
            v[m]    = 3'b111;
            ordy[m] = 1'b0;
        end
        repeat (5) begin
            cycle();
            chk("bp_data", od[1], 8'h22);
            chk("bp_sel", os[1], 1);
            chk("bp_valid", ov[1], 1);
            chk("bp_ready", ir[1], 3'b000);
        end
        for (int m = 0; m < 2; m++) ordy[m] = 1'b1;
        #1;
        chk("bp_release_ready", ir[1], 3'b100);
        cycle();
        chk("bp_release_data", od[1], 8'h33);
        chk("bp_release_sel", os[1], 2);

        // Asynchronous reset in the middle of a stall, away from any edge.
        for (int m = 0; m < 2; m++) ordy[m] = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_rr", ov[1], 0);
        chk("async_rst_valid_fp", ov[0], 0);
        chk("async_rst_data", od[1], 8'h00);
        reset_model();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) v[m] = '0;
        rst_n = 1'b1;
        cycle();

        repeat (1000) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
